result_store: RTL and testbench
===============================

# result_store

Write-back stage for convolution results. Accepts one DEPTH_NB-wide result vector per handshake from the `layers` result port (`result_bus`/`result_val`/`result_rdy`). Serialises each vector into GROUP_NB-lane beats and writes the beats to sequential addresses of the image buffer write port. Counts vectors per frame and pulses `frame_done` after the last beat of a frame is accepted.

## Interface
- CFG_DWIDTH, 32, config data width
- CFG_AWIDTH, 5, config address width
- DEPTH_NB, 16, result lanes per vector; must be a multiple of GROUP_NB
- GROUP_NB, 4, lanes per write beat
- IMG_WIDTH, 16, bits per lane
- BUF_AWIDTH, 12, buffer write address width
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- cfg_data  in  CFG_DWIDTH  config value
- cfg_addr  in  CFG_AWIDTH  config register select
- cfg_valid  in  1  config strobe
- result_bus  in  IMG_WIDTH*DEPTH_NB  result vector; lane i at [i*IMG_WIDTH +: IMG_WIDTH]
- result_val  in  1  vector valid; held until accepted
- result_rdy  out  1  ready for a vector
- wr_addr  out  BUF_AWIDTH  buffer write address
- wr_data  out  GROUP_NB*IMG_WIDTH  beat data
- wr_val  out  1  beat valid
- wr_rdy  in  1  buffer accepts beat
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- BEATS = DEPTH_NB/GROUP_NB.
- Config register CFG_STORE is written on `cfg_valid & (cfg_addr == CFG_STORE)`.
  - `cfg_data[BUF_AWIDTH-1:0]` sets `base`.
  - `cfg_data[31:16]` sets `frame_len`, encoded as vectors-per-frame minus 1.
  - Both registers reset to 0.
- `base` and `frame_len` are sampled into working copies when the first vector of a frame is captured (pix_cnt == 0). A config write mid-frame therefore affects only the next frame.
- FSM is one-hot with states RESET, READY, SEND, DONE.
  - RESET -> READY unconditionally.
  - READY: `result_rdy`=1. On `result_val` the vector is captured into the shift register, beat_cnt=0, and the FSM moves to SEND. If pix_cnt==0, `wr_addr` loads `base`.
  - SEND: `wr_val`=1 and `wr_data` = lanes [beat_cnt*GROUP_NB +: GROUP_NB] of the captured vector. On `wr_rdy`:
    - the register shifts down by GROUP_NB lanes;
    - `wr_addr` increments, wrapping modulo 2^BUF_AWIDTH;
    - beat_cnt increments.
  - Last beat (beat_cnt==BEATS-1) accepted:
    - if pix_cnt==frame_len: go to DONE;
    - else: pix_cnt increments and the FSM returns to READY.
  - DONE: `frame_done`=1 and pix_cnt clears. `wr_addr` holds the last+1 address. DONE -> READY.
- Vector k, beat b is written to base + k*BEATS + b (mod 2^BUF_AWIDTH).
- `wr_data` and `wr_addr` stay stable while `wr_val & ~wr_rdy`.
- `result_bus` is not sampled outside READY. Vector content is never altered, only reordered into beats.

## Timing
- Reset values: `result_rdy`=0, `wr_val`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, pix_cnt=0, beat_cnt=0. State is RESET for the cycle after `rst`; `result_rdy`=1 one cycle later.
- `result_rdy` and `wr_val` are decoded from state registers only. There is no combinational path from `result_val` or `wr_rdy` to outputs.
- With a vector captured at edge T, beat 0 is presented in cycle T+1.
- With `wr_rdy` held high, beats occupy T+1..T+BEATS and `result_rdy` returns at T+BEATS+1. Throughput is one vector per BEATS+1 cycles.
- `frame_done` is high exactly in the cycle after the last beat of vector frame_len is accepted. `result_rdy` is 0 in that cycle.
- `wr_rdy` low stalls SEND indefinitely with no data loss. `result_val` is ignored during SEND and DONE.
- frame_len==0: every vector is a full frame, and `wr_addr` reloads `base` each vector.
- `rst` mid-SEND: the FSM goes to RESET next edge, `wr_val` drops, and the partial vector is discarded. Config registers return to 0.
- cfg write in the same cycle as a first-vector capture: the old `base`/`frame_len` are used for that frame.

## Structure
- CFG_STORE address constant goes in the shared `cfg_parameters.vh`, alongside CFG_LAYERS.
- Sub-module: `beat_serialiser`. It contains the vector load register, lane shift, beat counter and last-beat flag, and is parameterised by DEPTH_NB/GROUP_NB/IMG_WIDTH.
- FSM, address pointer and pix_cnt stay in `result_store`.

## Test plan
All scenarios use DEPTH_NB=16, GROUP_NB=4, IMG_WIDTH=16 (BEATS=4).
- Single vector: cfg base=0x100, frame_len=0; send lanes 0..15 = 0x0000..0x000F with `wr_rdy`=1.
  - Beats go to addrs 0x100..0x103 with data {3,2,1,0},{7,6,5,4},{B,A,9,8},{F,E,D,C}.
  - `frame_done` pulses one cycle after the 0x103 accept.
- Frame of 3: frame_len=2, base=0x20, three vectors back-to-back.
  - 12 writes go to 0x20..0x2B.
  - One `frame_done` after 0x2B; none earlier.
  - `result_rdy` low 4 cycles per vector.
- Backpressure: `wr_rdy` toggles 1,0,0,1,... during a vector.
  - `wr_data`/`wr_addr` are held while stalled.
  - All 4 beats are delivered in order; no duplicates.
- Address wrap: BUF_AWIDTH=12, base=0xFFE, frame_len=0.
  - Writes go to 0xFFE, 0xFFF, 0x000, 0x001.
- Mid-frame config: frame_len=1, base=0x40; after vector 0, write base=0x80.
  - Vector 1 goes to 0x44..0x47.
  - The next frame starts at 0x80.
- Reset mid-SEND: assert `rst` after beat 1 accepted.
  - `wr_val`=0 next cycle.
  - `result_rdy`=1 two cycles after `rst` deasserts.
  - After reconfig, the next vector writes from the new base with pix_cnt=0.

Source files
------------

// File: rtl/result_store_pkg.sv
// Shared constants for the result write-back stage:
// config register map and one-hot FSM encoding.
package result_store_pkg;

  localparam logic [4:0] CFG_LAYERS = 5'h01;
  localparam logic [4:0] CFG_STORE  = 5'h02;

  localparam int ST_RESET = 0;
  localparam int ST_READY = 1;
  localparam int ST_SEND  = 2;
  localparam int ST_DONE  = 3;

  localparam logic [3:0] S_RESET = 4'b0001;
  localparam logic [3:0] S_READY = 4'b0010;
  localparam logic [3:0] S_SEND  = 4'b0100;
  localparam logic [3:0] S_DONE  = 4'b1000;

endpackage

// File: rtl/result_store_if.sv
// Config, result-vector and buffer-write handshakes of
// the result write-back stage.
interface result_store_if #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int DEPTH_NB   = 16,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int BUF_AWIDTH = 12
);

  logic [CFG_DWIDTH-1:0]          cfg_data;
  logic [CFG_AWIDTH-1:0]          cfg_addr;
  logic                           cfg_valid;
  logic [IMG_WIDTH*DEPTH_NB-1:0]  result_bus;
  logic                           result_val;
  logic                           result_rdy;
  logic [BUF_AWIDTH-1:0]          wr_addr;
  logic [GROUP_NB*IMG_WIDTH-1:0]  wr_data;
  logic                           wr_val;
  logic                           wr_rdy;
  logic                           frame_done;

  modport master (
    output cfg_data, cfg_addr, cfg_valid,
    output result_bus, result_val,
    output wr_rdy,
    input  result_rdy, wr_addr, wr_data,
    input  wr_val, frame_done
  );

  modport slave (
    input  cfg_data, cfg_addr, cfg_valid,
    input  result_bus, result_val,
    input  wr_rdy,
    output result_rdy, wr_addr, wr_data,
    output wr_val, frame_done
  );

endinterface

// File: rtl/result_store_beat_serialiser.sv
// beat_serialiser: holds one result vector and shifts it
// out GROUP_NB lanes per accepted beat.
module result_store_beat_serialiser #(
  parameter int DEPTH_NB  = 16,
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [DEPTH_NB*IMG_WIDTH-1:0] vec_in,
  input  logic                          advance,
  output logic [GROUP_NB*IMG_WIDTH-1:0] beat_data,
  output logic                          last
);

  localparam int BEATS = DEPTH_NB / GROUP_NB;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VW    = DEPTH_NB * IMG_WIDTH;
  localparam int GW    = GROUP_NB * IMG_WIDTH;

  logic [VW-1:0] vec;
  logic [BW-1:0] beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      vec      <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      vec      <= vec_in;
      beat_cnt <= '0;
    end else if (advance) begin
      vec      <= vec >> GW;
      beat_cnt <= last ? '0 : beat_cnt + 1'b1;
    end
  end

  // Current beat always sits in the low lanes
  assign beat_data = vec[GW-1:0];
  assign last      = (beat_cnt == BW'(BEATS - 1));

endmodule

// File: rtl/result_store.sv
// Write-back stage: serialises result vectors into beats
// at sequential buffer addresses, framing by vector count.
import result_store_pkg::*;

module result_store #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int DEPTH_NB   = 16,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int BUF_AWIDTH = 12
) (
  input  logic           clk,
  input  logic           rst,
  result_store_if.slave  bus
);

  logic [3:0]            state;
  logic [3:0]            state_nx;
  logic [BUF_AWIDTH-1:0] base;
  logic [15:0]           frame_len;
  logic [15:0]           flen_w;
  logic [15:0]           pix_cnt;
  logic [BUF_AWIDTH-1:0] wr_addr;
  logic                  capture;
  logic                  beat_acc;
  logic                  last;
  logic                  cfg_hit;
  logic                  first;
  logic                  frame_end;

  assign capture   = state[ST_READY] & bus.result_val;
  assign beat_acc  = state[ST_SEND] & bus.wr_rdy;
  assign cfg_hit   = bus.cfg_valid &
                     (bus.cfg_addr == CFG_AWIDTH'(CFG_STORE));
  assign first     = (pix_cnt == '0);
  assign frame_end = (pix_cnt == flen_w);

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state[ST_RESET]: state_nx = S_READY;
      state[ST_READY]: if (bus.result_val) state_nx = S_SEND;
      state[ST_SEND]:
        if (bus.wr_rdy && last)
          state_nx = frame_end ? S_DONE : S_READY;
      state[ST_DONE]:  state_nx = S_READY;
      default:         state_nx = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET;
      base      <= '0;
      frame_len <= '0;
      flen_w    <= '0;
      pix_cnt   <= '0;
      wr_addr   <= '0;
    end else begin
      state <= state_nx;
      if (cfg_hit) begin
        base      <= bus.cfg_data[BUF_AWIDTH-1:0];
        frame_len <= bus.cfg_data[31:16];
      end
      // Working copies latch at frame start only
      if (capture && first) begin
        wr_addr <= base;
        flen_w  <= frame_len;
      end
      if (beat_acc) wr_addr <= wr_addr + 1'b1;
      if (beat_acc && last && !frame_end)
        pix_cnt <= pix_cnt + 1'b1;
      if (state[ST_DONE]) pix_cnt <= '0;
    end
  end

  result_store_beat_serialiser #(
    .DEPTH_NB  (DEPTH_NB),
    .GROUP_NB  (GROUP_NB),
    .IMG_WIDTH (IMG_WIDTH)
  ) u_beat_serialiser (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .vec_in    (bus.result_bus),
    .advance   (beat_acc),
    .beat_data (bus.wr_data),
    .last      (last)
  );

  assign bus.result_rdy = state[ST_READY];
  assign bus.wr_val     = state[ST_SEND];
  assign bus.frame_done = state[ST_DONE];
  assign bus.wr_addr    = wr_addr;

endmodule

// File: tb/tb_result_store.sv
// Scoreboard bench for result_store: directed vectors,
// expected beats queued at issue, checked by a monitor.
`timescale 1ns/1ps
module tb_result_store;
  import result_store_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_store_if #(
    .CFG_DWIDTH(32), .CFG_AWIDTH(5), .DEPTH_NB(16),
    .GROUP_NB(4), .IMG_WIDTH(16), .BUF_AWIDTH(12)
  ) bus ();

  result_store #(
    .CFG_DWIDTH(32), .CFG_AWIDTH(5), .DEPTH_NB(16),
    .GROUP_NB(4), .IMG_WIDTH(16), .BUF_AWIDTH(12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t     q[$];
  int       checks = 0;
  int       errors = 0;
  bit [7:0] rdy_pat = 8'hFF;
  bit       done_pending = 1'b0;

  initial begin
    int rp;
    rp = 0;
    bus.wr_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.wr_rdy = rdy_pat[rp % 8];
      rp++;
    end
  end

  always @(negedge clk) begin
    if (bus.frame_done || done_pending) begin
      checks++;
      if (bus.frame_done !== done_pending) begin
        errors++;
        $display("FAIL frame_done: got %b want %b at %0t",
                 bus.frame_done, done_pending, $time);
      end
    end
    done_pending = 1'b0;
    if (bus.wr_val) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected addr %h data %h",
                 bus.wr_addr, bus.wr_data);
      end else begin
        if (bus.wr_addr !== q[0].addr ||
            bus.wr_data !== q[0].data) begin
          errors++;
          $display("FAIL beat: got %h/%h want %h/%h",
                   bus.wr_addr, bus.wr_data,
                   q[0].addr, q[0].data);
        end
        if (bus.wr_rdy) begin
          done_pending = q[0].last;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic logic [255:0] mkvec(input logic [15:0] s);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = s + 16'(i);
    return v;
  endfunction

  task automatic cfg_write(input logic [11:0] b,
                           input logic [15:0] fl);
    bus.cfg_addr  = CFG_STORE;
    bus.cfg_data  = {fl, 4'h0, b};
    bus.cfg_valid = 1'b1;
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
  endtask

  task automatic push_beats(input logic [255:0] v,
                            input logic [11:0] a0,
                            input bit lastv, input int nb);
    for (int b = 0; b < nb; b++) begin
      exp_t e;
      e.addr = a0 + 12'(b);
      e.data = v[b*64 +: 64];
      e.last = lastv && (b == 3);
      q.push_back(e);
    end
  endtask

  task automatic capture(input logic [255:0] v);
    int n;
    n = 0;
    bus.result_bus = v;
    bus.result_val = 1'b1;
    while (!bus.result_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL capture: result_rdy %b want 1",
               bus.result_rdy);
    end
    @(posedge clk);
    #1;
    bus.result_val = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.result_bus = ~v;
  endtask

  task automatic measure(input int exp_low);
    int low;
    low = 0;
    do begin
      @(negedge clk);
      if (!bus.result_rdy) low++;
    end while (!bus.result_rdy && low < 200);
    if (exp_low > 0) chk("rdy_low_cycles", 64'(low), 64'(exp_low));
    else if (low >= 200) chk("rdy_return", 64'(low), 64'd0);
  endtask

  task automatic send_vec(input logic [255:0] v,
                          input logic [11:0] a0,
                          input bit lastv, input int exp_low);
    push_beats(v, a0, lastv, 4);
    capture(v);
    measure(exp_low);
  endtask

  initial begin
    logic [255:0] v1;
    int n;
    bus.cfg_data   = '0;
    bus.cfg_addr   = '0;
    bus.cfg_valid  = 1'b0;
    bus.result_bus = '0;
    bus.result_val = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result_rdy", 64'(bus.result_rdy), 64'd0);
    chk("rst_wr_val",     64'(bus.wr_val),     64'd0);
    chk("rst_wr_addr",    64'(bus.wr_addr),    64'd0);
    chk("rst_wr_data",    bus.wr_data,         64'd0);
    chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state_rdy", 64'(bus.result_rdy), 64'd0);
    @(negedge clk);
    chk("ready_after_rst", 64'(bus.result_rdy), 64'd1);

    // Single vector, lanes 0..15
    cfg_write(12'h100, 16'd0);
    v1 = mkvec(16'h0000);
    q.push_back('{12'h100, 64'h0003_0002_0001_0000, 1'b0});
    q.push_back('{12'h101, 64'h0007_0006_0005_0004, 1'b0});
    q.push_back('{12'h102, 64'h000B_000A_0009_0008, 1'b0});
    q.push_back('{12'h103, 64'h000F_000E_000D_000C, 1'b1});
    capture(v1);
    measure(5);

    // Config write coincident with first capture
    bus.cfg_addr  = CFG_STORE;
    bus.cfg_data  = {16'd0, 4'h0, 12'h500};
    bus.cfg_valid = 1'b1;
    send_vec(mkvec(16'h1100), 12'h100, 1'b1, 5);
    send_vec(mkvec(16'h1200), 12'h500, 1'b1, 5);

    // Frame of three
    cfg_write(12'h020, 16'd2);
    send_vec(mkvec(16'h2000), 12'h020, 1'b0, 4);
    send_vec(mkvec(16'h2100), 12'h024, 1'b0, 4);
    send_vec(mkvec(16'h2200), 12'h028, 1'b1, 5);

    // Backpressure
    cfg_write(12'h200, 16'd0);
    rdy_pat = 8'b1001_1001;
    send_vec(mkvec(16'h3000), 12'h200, 1'b1, 0);
    rdy_pat = 8'hFF;
    repeat (2) @(negedge clk);

    // Address wrap
    cfg_write(12'hFFE, 16'd0);
    send_vec(mkvec(16'h4000), 12'hFFE, 1'b1, 5);

    // Mid-frame config
    cfg_write(12'h040, 16'd1);
    send_vec(mkvec(16'h5000), 12'h040, 1'b0, 4);
    cfg_write(12'h080, 16'd1);
    send_vec(mkvec(16'h5100), 12'h044, 1'b1, 5);
    send_vec(mkvec(16'h5200), 12'h080, 1'b0, 4);
    send_vec(mkvec(16'h5300), 12'h084, 1'b1, 5);

    // Reset during SEND of vector 1
    cfg_write(12'h600, 16'd1);
    send_vec(mkvec(16'h6000), 12'h600, 1'b0, 4);
    push_beats(mkvec(16'h6100), 12'h604, 1'b0, 2);
    capture(mkvec(16'h6100));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.wr_val && bus.wr_rdy &&
                 bus.wr_addr == 12'h605) && n < 50);
    if (n >= 50) chk("beat1_seen", 64'(n), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_send_wr_val", 64'(bus.wr_val), 64'd0);
    chk("rst_send_rdy",    64'(bus.result_rdy), 64'd0);
    chk("rst_send_queue",  64'(q.size()), 64'd0);
    @(negedge clk);
    chk("rst_send_ready",  64'(bus.result_rdy), 64'd1);
    send_vec(mkvec(16'h7000), 12'h000, 1'b1, 5);
    cfg_write(12'h300, 16'd0);
    send_vec(mkvec(16'h7100), 12'h300, 1'b1, 5);

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
